fc_layer_sequencer: RTL and testbench

FC_LAYER_SEQUENCER -- requirements
Module: fc_layer_sequencer

---
 rtl/fc_layer_sequencer.sv | 135 +++++++++++++
 tb/tb_fc_layer_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// Control sequencer for a two-layer fully-connected inference: streams layer-1
// ROM addresses, then walks each layer-2 neuron window of K+LAT+1 cycles.
module fc_layer_sequencer #(
    parameter int unsigned K   = 16,
    parameter int unsigned N2  = 10,
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [8:0]  addr_bw1,
    output logic        wren1,
    output logic [8:0]  address_read_2,
    output logic [16:0] address_weight_2,
    output logic [7:0]  addr_biase_2,
    output logic        biase_ena_2,
    output logic        wren2
);

    localparam int unsigned N1      = 16 * K;
    localparam int unsigned A1_W    = 10;
    localparam int unsigned C_W     = 6;
    localparam int unsigned J_W     = 8;
    localparam int unsigned IDX_W   = 13;
    localparam int unsigned A1_LAST = N1 + LAT - 1;
    localparam int unsigned C_LAST  = K + LAT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        L1_RUN = 2'd1,
        L2_RUN = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [A1_W-1:0]   a1_q, a1_d;
    logic [C_W-1:0]    c_q, c_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [IDX_W-1:0]  jk_q, jk_d;

    logic [C_W-1:0]    cr_d;
    logic [IDX_W-1:0]  widx_d;
    logic              in_l1_d, in_l2_d;

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        a1_d    = a1_q;
        c_d     = c_q;
        j_d     = j_q;
        jk_d    = jk_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = L1_RUN;
                    a1_d    = '0;
                end
            end
            L1_RUN: begin
                if (a1_q == A1_W'(A1_LAST)) begin
                    state_d = L2_RUN;
                    a1_d    = '0;
                    c_d     = '0;
                    j_d     = '0;
                    jk_d    = '0;
                end else begin
                    a1_d = a1_q + A1_W'(1);
                end
            end
            L2_RUN: begin
                if (c_q == C_W'(C_LAST)) begin
                    c_d = '0;
                    if (j_q == J_W'(N2 - 1)) begin
                        state_d = DONE;
                        j_d     = '0;
                        jk_d    = '0;
                    end else begin
                        j_d  = j_q + J_W'(1);
                        jk_d = jk_q + IDX_W'(K);
                    end
                end else begin
                    c_d = c_q + C_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from next-state values so the registered outputs line up
    // with the state they describe; the chunk index saturates at K-1.
    always_comb begin
        in_l1_d = (state_d == L1_RUN);
        in_l2_d = (state_d == L2_RUN);
        cr_d    = (c_d < C_W'(K)) ? c_d : C_W'(K - 1);
        widx_d  = jk_d + IDX_W'(cr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            a1_q             <= '0;
            c_q              <= '0;
            j_q              <= '0;
            jk_q             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            addr_bw1         <= '0;
            wren1            <= 1'b0;
            address_read_2   <= '0;
            address_weight_2 <= '0;
            addr_biase_2     <= '0;
            biase_ena_2      <= 1'b0;
            wren2            <= 1'b0;
        end else begin
            state_q          <= state_d;
            a1_q             <= a1_d;
            c_q              <= c_d;
            j_q              <= j_d;
            jk_q             <= jk_d;
            busy             <= (state_d != IDLE);
            done             <= (state_d == DONE);
            addr_bw1         <= in_l1_d ? 9'(a1_d) : 9'd0;
            wren1            <= in_l1_d && (a1_d >= A1_W'(LAT));
            address_read_2   <= in_l2_d ? 9'(cr_d) : 9'd0;
            address_weight_2 <= in_l2_d ? {widx_d, 4'b0000} : 17'd0;
            addr_biase_2     <= in_l2_d ? j_d : 8'd0;
            biase_ena_2      <= in_l2_d && (c_d == C_W'(LAT));
            wren2            <= in_l2_d && (c_d == C_W'(C_LAST));
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer at K=16, N2=10, LAT=2: hand-computed
// vector table plus a cycle-indexed reference of the inference schedule.
module tb_fc_layer_sequencer;

    typedef struct packed {
        logic [8:0]  a1;
        logic        w1;
        logic [8:0]  rd;
        logic [16:0] wt;
        logic [7:0]  b2;
        logic        be;
        logic        w2;
        logic        busy;
        logic        done;
    } out_t;

    typedef struct {
        int    cyc;
        out_t  exp;
        string name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, wren1, biase_ena_2, wren2;
    logic [8:0]  addr_bw1, address_read_2;
    logic [16:0] address_weight_2;
    logic [7:0]  addr_biase_2;

    int n_vec = 0;
    int n_err = 0;
    out_t rec [0:499];
    vec_t vecs [$];

    fc_layer_sequencer #(.K(16), .N2(10), .LAT(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .addr_bw1         (addr_bw1),
        .wren1            (wren1),
        .address_read_2   (address_read_2),
        .address_weight_2 (address_weight_2),
        .addr_biase_2     (addr_biase_2),
        .biase_ena_2      (biase_ena_2),
        .wren2            (wren2)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(int a1, bit w1, int rd, int wt, int b2,
                                bit be, bit w2, bit bsy, bit dn);
        out_t o;
        o.a1 = 9'(a1); o.w1 = w1; o.rd = 9'(rd); o.wt = 17'(wt);
        o.b2 = 8'(b2); o.be = be; o.w2 = w2; o.busy = bsy; o.done = dn;
        return o;
    endfunction

    function automatic out_t snap();
        return mk(int'(addr_bw1), wren1, int'(address_read_2), int'(address_weight_2),
                  int'(addr_biase_2), biase_ena_2, wren2, busy, done);
    endfunction

    // Expected outputs n cycles after the start-sampling edge
    function automatic out_t model(int n);
        int m, j, c, cr;
        if (n >= 1 && n <= 258)
            return mk(n - 1, (n - 1) >= 2, 0, 0, 0, 0, 0, 1, 0);
        if (n >= 259 && n <= 448) begin
            m  = n - 259;
            j  = m / 19;
            c  = m % 19;
            cr = (c < 16) ? c : 15;
            return mk(0, 0, cr, (j * 16 + cr) * 16, j, c == 2, c == 18, 1, 0);
        end
        if (n == 449)
            return mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check(input string name, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Capture L cycles; start is dropped after cycle 1 unless held, and
    // re-pulsed at cycles inj1/inj2 to probe that it is ignored when busy.
    task automatic run(input int len, input int inj1, input int inj2, input bit hold);
        for (int n = 1; n <= len; n++) begin
            @(negedge clk);
            rec[n] = snap();
            if (!hold) start = (n == inj1) || (n == inj2);
        end
    endtask

    task automatic check_model(input string label, input int last);
        for (int n = 1; n <= last; n++)
            check($sformatf("%s_c%0d", label, n), rec[n], model(n));
    endtask

    task automatic check_aggr(input string label, input int last);
        int nw1, nw2, ndone, dcyc, w2k;
        nw1 = 0; nw2 = 0; ndone = 0; dcyc = -1; w2k = 0;
        for (int n = 1; n <= last; n++) begin
            if (rec[n].w1) nw1++;
            if (rec[n].done) begin
                ndone++;
                if (dcyc < 0) dcyc = n;
            end
            if (rec[n].w2) begin
                check_int($sformatf("%s_w2cyc%0d", label, w2k), n, 277 + 19 * w2k);
                check_int($sformatf("%s_w2addr%0d", label, w2k), int'(rec[n].b2), w2k);
                w2k++;
                nw2++;
            end
        end
        check_int({label, "_wren1_cnt"}, nw1, 256);
        check_int({label, "_wren2_cnt"}, nw2, 10);
        check_int({label, "_done_cnt"}, ndone, 1);
        check_int({label, "_done_cyc"}, dcyc, 449);
    endtask

    initial begin
        out_t zero;
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back('{1,   mk(0,   0, 0,  0,    0, 0, 0, 1, 0), "l1_first"});
        vecs.push_back('{2,   mk(1,   0, 0,  0,    0, 0, 0, 1, 0), "l1_pre_wr"});
        vecs.push_back('{3,   mk(2,   1, 0,  0,    0, 0, 0, 1, 0), "l1_first_wr"});
        vecs.push_back('{258, mk(257, 1, 0,  0,    0, 0, 0, 1, 0), "l1_last"});
        vecs.push_back('{259, mk(0,   0, 0,  0,    0, 0, 0, 1, 0), "l2_j0_c0"});
        vecs.push_back('{261, mk(0,   0, 2,  32,   0, 1, 0, 1, 0), "l2_j0_bias"});
        vecs.push_back('{274, mk(0,   0, 15, 240,  0, 0, 0, 1, 0), "l2_j0_c15"});
        vecs.push_back('{276, mk(0,   0, 15, 240,  0, 0, 0, 1, 0), "l2_j0_hold"});
        vecs.push_back('{277, mk(0,   0, 15, 240,  0, 0, 1, 1, 0), "l2_j0_wr"});
        vecs.push_back('{316, mk(0,   0, 0,  768,  3, 0, 0, 1, 0), "l2_j3_c0"});
        vecs.push_back('{318, mk(0,   0, 2,  800,  3, 1, 0, 1, 0), "l2_j3_bias"});
        vecs.push_back('{331, mk(0,   0, 15, 1008, 3, 0, 0, 1, 0), "l2_j3_c15"});
        vecs.push_back('{334, mk(0,   0, 15, 1008, 3, 0, 1, 1, 0), "l2_j3_wr"});
        vecs.push_back('{448, mk(0,   0, 15, 2544, 9, 0, 1, 1, 0), "l2_j9_wr"});
        vecs.push_back('{449, mk(0,   0, 0,  0,    0, 0, 0, 1, 1), "done"});
        vecs.push_back('{450, zero, "idle_after"});

        // Reset state, with start asserted while still in reset
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        check("reset_state", snap(), zero);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ignores_start", snap(), zero);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", snap(), zero);

        // Run A: single start pulse
        start = 1'b1;
        run(455, 0, 0, 0);
        foreach (vecs[i])
            check(vecs[i].name, rec[vecs[i].cyc], vecs[i].exp);
        check_model("runA", 455);
        check_aggr("runA", 455);

        // Run B: start pulsed during L1_RUN and L2_RUN
        @(negedge clk);
        start = 1'b1;
        run(455, 50, 300, 0);
        check_model("runB", 455);
        check_aggr("runB", 455);

        // Asynchronous reset in the j=5 window, mid-cycle
        @(negedge clk);
        start = 1'b1;
        run(359, 0, 0, 0);
        check("pre_rst_j5", rec[359], model(359));
        #2 rst_n = 1'b0;
        #1 check("async_rst", snap(), zero);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("in_rst_%0d", i), snap(), zero);
        end

        // Release with start already high: first edge after release samples it
        rst_n = 1'b1;
        start = 1'b1;
        run(455, 0, 0, 0);
        check_model("restart", 455);
        check_aggr("restart", 455);

        // start held high across two runs
        @(negedge clk);
        start = 1'b1;
        run(455, 0, 0, 1);
        check_model("held", 449);
        check("held_idle_gap", rec[450], zero);
        check("held_rerun0", rec[451], mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        check("held_rerun1", rec[452], mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
